// File: rtl/temp_pwm_regulator_if.sv
// Temperature sample stream from the sensor front-end into the regulator.
// The producer drives valid/temp; the regulator drives ready.
interface temp_pwm_regulator_if #(
  parameter int unsigned TEMP_W = 16
) ();
  logic              s_valid;
  logic              s_ready;
  logic [TEMP_W-1:0] s_temp;

  modport master (output s_valid, output s_temp, input s_ready);
  modport slave  (input s_valid, input s_temp, output s_ready);
endinterface

// File: rtl/temp_pwm_regulator.sv
// Proportional heater regulator: sample pipeline, OFF/REGULATE/OVERSHOOT/FAULT control,
// sample-timeout fault and a period-aligned heater PWM.
module temp_pwm_regulator #(
  parameter int unsigned TEMP_W      = 16,
  parameter int unsigned DUTY_W      = 8,
  parameter int unsigned KP_SHIFT    = 4,
  parameter int unsigned PRESCALE    = 100,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  enable,
  input  logic [TEMP_W-1:0]     setpoint,
  input  logic [TEMP_W-1:0]     hysteresis,
  input  logic [7:0]            kp,
  input  logic                  fault_clr,
  temp_pwm_regulator_if.slave   s,
  output logic [TEMP_W-1:0]     temp_last,
  output logic [DUTY_W-1:0]     duty,
  output logic [1:0]            state,
  output logic                  fault,
  output logic                  heater_pwm
);

  typedef enum logic [1:0] {
    StOff       = 2'd0,
    StRegulate  = 2'd1,
    StOvershoot = 2'd2,
    StFault     = 2'd3
  } state_e;

  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);
  localparam logic [DUTY_W-1:0] PwmLast = '1;
  localparam logic signed [TEMP_W+9:0] DutyMax =
    {{(TEMP_W + 10 - DUTY_W){1'b0}}, {DUTY_W{1'b1}}};

  // ---------------- sample handshake and compute pipeline ----------------
  logic [1:0]             busy_q;
  logic                   accept;
  logic                   v0_q, v1_q, v2_q;
  logic [TEMP_W-1:0]      temp_q;
  logic signed [TEMP_W:0] err_q, err_d, sp1, t1;
  logic [DUTY_W-1:0]      dcalc_q, dcalc_d;
  logic signed [TEMP_W+9:0] err_x, kp_x, prod, shifted;

  assign s.s_ready = (busy_q == 2'd0);
  assign accept    = s.s_valid & s.s_ready;
  assign temp_last = temp_q;

  always_comb begin
    sp1     = {setpoint[TEMP_W-1], setpoint};
    t1      = {temp_q[TEMP_W-1], temp_q};
    err_d   = sp1 - t1;
    err_x   = {{9{err_q[TEMP_W]}}, err_q};
    kp_x    = {{(TEMP_W + 2){1'b0}}, kp};
    prod    = err_x * kp_x;
    shifted = prod >>> KP_SHIFT;
    if (shifted[TEMP_W+9]) begin
      dcalc_d = '0;
    end else if (shifted > DutyMax) begin
      dcalc_d = '1;
    end else begin
      dcalc_d = shifted[DUTY_W-1:0];
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      busy_q  <= 2'd0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      temp_q  <= '0;
      err_q   <= '0;
      dcalc_q <= '0;
    end else begin
      if (accept) begin
        busy_q <= 2'd2;
      end else if (busy_q != 2'd0) begin
        busy_q <= busy_q - 2'd1;
      end
      v0_q <= accept;
      v1_q <= v0_q;
      v2_q <= v1_q;
      if (accept) temp_q <= s.s_temp;
      if (v0_q)   err_q <= err_d;
      if (v1_q)   dcalc_q <= dcalc_d;
    end
  end

  // ---------------- control FSM and sample timeout ----------------
  state_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_next_q, duty_next_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic signed [TEMP_W+1:0] sp2, hys2, t2, band_hi, band_lo;
  logic              active, timeout;

  always_comb begin
    sp2     = {{2{setpoint[TEMP_W-1]}}, setpoint};
    hys2    = {2'b00, hysteresis};
    t2      = {{2{temp_q[TEMP_W-1]}}, temp_q};
    band_hi = sp2 + hys2;
    band_lo = sp2 - hys2;
    active  = (state_q == StRegulate) || (state_q == StOvershoot);
    // An accept on the terminal count restarts the window instead of faulting.
    timeout = active && !accept && (cnt_q == CntLast);
    cnt_d   = (active && !accept && (cnt_q != CntLast)) ? cnt_q + 1'b1 : '0;

    state_d     = state_q;
    duty_next_d = duty_next_q;
    if (state_q == StFault) begin
      duty_next_d = '0;
      if (fault_clr) state_d = StOff;
    end else if (!enable) begin
      state_d     = StOff;
      duty_next_d = '0;
    end else if (timeout) begin
      state_d     = StFault;
      duty_next_d = '0;
    end else begin
      case (state_q)
        StOff: state_d = StRegulate;
        StRegulate: begin
          if (v2_q) begin
            if (t2 >= band_hi) begin
              state_d     = StOvershoot;
              duty_next_d = '0;
            end else begin
              duty_next_d = dcalc_q;
            end
          end
        end
        default: begin
          duty_next_d = '0;
          if (v2_q && (t2 <= band_lo)) begin
            state_d     = StRegulate;
            duty_next_d = dcalc_q;
          end
        end
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= StOff;
      duty_next_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      duty_next_q <= duty_next_d;
      cnt_q       <= cnt_d;
    end
  end

  assign state = state_q;
  assign fault = (state_q == StFault);

  // ---------------- PWM ----------------
  logic [PreW-1:0]   pre_q, pre_d;
  logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d, duty_q, duty_d;
  logic              heater_q, heater_d, tick, quiet;

  always_comb begin
    tick      = (pre_q == PreLast);
    pre_d     = tick ? '0 : pre_q + 1'b1;
    pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    quiet     = (state_d == StOff) || (state_d == StFault);
    duty_d    = duty_q;
    // Duty only changes on a period boundary, except shutdown which is immediate.
    if (quiet) begin
      duty_d = '0;
    end else if (tick && (pwm_cnt_q == PwmLast)) begin
      duty_d = duty_next_q;
    end
    heater_d = !quiet && (pwm_cnt_d < duty_d);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      pre_q     <= '0;
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      heater_q  <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      heater_q  <= heater_d;
    end
  end

  assign duty       = duty_q;
  assign heater_pwm = heater_q;

endmodule

// File: tb/tb_temp_pwm_regulator.sv
// Self-checking bench for temp_pwm_regulator: cycle-indexed behavioural model plus
// directed literal checks and randomized sample traffic.
module tb_temp_pwm_regulator;
  localparam int T = 1000;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic enable = 1'b0;
  logic fault_clr = 1'b0;
  logic signed [15:0] setpoint = '0;
  logic [15:0] hysteresis = '0;
  logic [7:0]  kp = '0;
  logic [15:0] temp_last;
  logic [7:0]  duty;
  logic [1:0]  state;
  logic        fault, heater_pwm;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  temp_pwm_regulator_if #(.TEMP_W(16)) sif ();

  temp_pwm_regulator #(
    .TEMP_W(16), .DUTY_W(8), .KP_SHIFT(4), .PRESCALE(1), .TIMEOUT_CYC(T)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .enable(enable), .setpoint(setpoint),
    .hysteresis(hysteresis), .kp(kp), .fault_clr(fault_clr), .s(sif),
    .temp_last(temp_last), .duty(duty), .state(state), .fault(fault),
    .heater_pwm(heater_pwm)
  );

  always #5 ACLK = ~ACLK;

  // Model: everything indexed by clock edges since reset (cyc).
  typedef struct packed {
    int cyc; int last_acc; int st; int duty_next; int duty; int heater;
    int temp_last; int idle; int p_valid; int p_due; int p_temp;
  } model_t;
  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.last_acc = -100;
    return r;
  endfunction

  function automatic int target_duty(int sp, int t, int k);
    int v;
    v = ((sp - t) * k) >>> 4;
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic model_t model_step(model_t o, bit valid, int temp, bit en, int sp,
                                        int hys, int k, bit clr);
    model_t n;
    bit acc, dv, act, tmo;
    int pos;
    n     = o;
    n.cyc = o.cyc + 1;
    acc   = valid && ((o.cyc - o.last_acc) >= 3);
    dv    = (o.p_valid != 0) && (o.p_due == o.cyc);
    act   = (o.st == 1) || (o.st == 2);
    tmo   = act && !acc && (o.idle == T - 1);
    if (dv) n.p_valid = 0;
    if (acc) begin
      n.last_acc = o.cyc; n.temp_last = temp;
      n.p_valid = 1; n.p_due = o.cyc + 3; n.p_temp = temp;
    end
    if (o.st == 3) begin
      n.duty_next = 0;
      if (clr) n.st = 0;
    end else if (!en) begin
      n.st = 0; n.duty_next = 0;
    end else if (tmo) begin
      n.st = 3; n.duty_next = 0;
    end else if (o.st == 0) begin
      n.st = 1;
    end else if (o.st == 1) begin
      if (dv) begin
        if (o.p_temp >= sp + hys) begin n.st = 2; n.duty_next = 0; end
        else n.duty_next = target_duty(sp, o.p_temp, k);
      end
    end else begin
      n.duty_next = 0;
      if (dv && (o.p_temp <= sp - hys)) begin
        n.st = 1; n.duty_next = target_duty(sp, o.p_temp, k);
      end
    end
    n.idle = (act && !acc && !tmo) ? o.idle + 1 : 0;
    pos = n.cyc % 256;
    if (n.st == 0 || n.st == 3) n.duty = 0;
    else if (pos == 0) n.duty = o.duty_next;
    n.heater = (n.st != 0 && n.st != 3 && pos < n.duty) ? 1 : 0;
    return n;
  endfunction

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) m <= model_reset();
    else m <= model_step(m, sif.s_valid, int'($signed(sif.s_temp)), enable, int'(setpoint),
                         int'(hysteresis), int'(kp), fault_clr);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  always @(negedge ACLK) begin
    if (run_cmp) begin
      chk("cmp_s_ready", int'(sif.s_ready), int'((m.cyc - m.last_acc) >= 3));
      chk("cmp_temp_last", int'($signed(temp_last)), m.temp_last);
      chk("cmp_state", int'(state), m.st);
      chk("cmp_fault", int'(fault), int'(m.st == 3));
      chk("cmp_duty", int'(duty), m.duty);
      chk("cmp_heater", int'(heater_pwm), m.heater);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic send(input int t);
    int k = 0;
    while (!sif.s_ready && k < 10) begin
      @(negedge ACLK);
      k++;
    end
    if (k >= 10) bound_expired("send_ready");
    sif.s_valid = 1'b1;
    sif.s_temp  = 16'(t);
    @(negedge ACLK);
    sif.s_valid = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    int k = 0;
    while ((m.cyc % 256) != p && k < 600) begin
      @(negedge ACLK);
      k++;
    end
    if (k >= 600) bound_expired("wait_pos");
  endtask

  task automatic count_high(input string name, input int exp);
    int hi = 0;
    repeat (256) begin
      @(negedge ACLK);
      hi += int'(heater_pwm);
    end
    chk(name, hi, exp);
  endtask

  initial begin
    int acc_cnt, acc_t, t, k;
    sif.s_valid = 1'b0;
    sif.s_temp  = '0;
    #23;
    chk("rst_state", int'(state), 0);
    chk("rst_duty", int'(duty), 0);
    chk("rst_s_ready", int'(sif.s_ready), 1);
    chk("rst_heater", int'(heater_pwm), 0);
    chk("rst_temp_last", int'(temp_last), 0);
    @(negedge ACLK);
    ARESET  = 1'b0;
    run_cmp = 1'b1;

    // Proportional
    setpoint = 16'sd400; hysteresis = 16'd8; kp = 8'd16; enable = 1'b1;
    cyc(3);
    chk("enter_regulate", int'(state), 1);
    send(384); cyc(300);
    chk("duty_16", int'(duty), 16);
    count_high("pwm_high_16", 16);
    send(200); cyc(300);
    chk("duty_200", int'(duty), 200);
    send(100); cyc(300);
    chk("duty_clamp_255", int'(duty), 255);
    count_high("pwm_high_255", 255);

    // Mid-period change waits for the wrap
    wait_pos(10);
    send(384); cyc(5);
    chk("duty_held_mid_period", int'(duty), 255);
    cyc(260);
    chk("duty_after_wrap", int'(duty), 16);

    // Hysteresis
    send(410); cyc(300);
    chk("overshoot_state", int'(state), 2);
    chk("overshoot_duty", int'(duty), 0);
    send(395); cyc(10);
    chk("overshoot_hold", int'(state), 2);
    send(392); cyc(300);
    chk("release_state", int'(state), 1);
    chk("release_duty", int'(duty), 8);

    // Handshake with valid held high
    cyc(3);
    acc_cnt = 0; acc_t = 0;
    for (int i = 0; i < 30; i++) begin
      t = int'($urandom_range(420, 380));
      sif.s_valid = 1'b1;
      sif.s_temp  = 16'(t);
      chk("ready_pattern", int'(sif.s_ready), int'(i % 3 == 0));
      if (i % 3 == 1) chk("temp_last_follow", int'(temp_last), acc_t);
      if (sif.s_ready) begin
        acc_cnt++;
        acc_t = t;
      end
      @(negedge ACLK);
    end
    sif.s_valid = 1'b0;
    chk("accept_count", acc_cnt, 10);

    // Accept on the timeout terminal count
    send(390); cyc(5);
    chk("pre_coincident_state", int'(state), 1);
    k = 0;
    while (m.idle != T - 1 && k < 2000) begin
      @(negedge ACLK);
      k++;
    end
    if (k >= 2000) bound_expired("wait_terminal");
    sif.s_valid = 1'b1;
    sif.s_temp  = 16'sd390;
    @(negedge ACLK);
    sif.s_valid = 1'b0;
    cyc(5);
    chk("no_fault_coincident", int'(state), 1);

    // Timeout fault
    cyc(1100);
    chk("fault_state", int'(state), 3);
    chk("fault_flag", int'(fault), 1);
    chk("fault_heater", int'(heater_pwm), 0);
    enable = 1'b0; cyc(3);
    chk("fault_ignore_en0", int'(state), 3);
    enable = 1'b1; cyc(3);
    chk("fault_ignore_en1", int'(state), 3);
    enable = 1'b0; fault_clr = 1'b1;
    @(negedge ACLK);
    fault_clr = 1'b0;
    cyc(1);
    chk("clr_to_off", int'(state), 0);
    enable = 1'b1; cyc(2);
    chk("off_to_regulate", int'(state), 1);

    // Extreme operands
    setpoint = 16'sd32767; kp = 8'd255; cyc(3);
    send(-32768); cyc(300);
    chk("extreme_duty", int'(duty), 255);

    // Randomized traffic
    for (int blk = 0; blk < 6; blk++) begin
      cyc(5);
      setpoint   = 16'($urandom_range(500, 300));
      hysteresis = 16'($urandom_range(40, 0));
      kp         = 8'($urandom_range(255, 0));
      for (int j = 0; j < 100; j++) begin
        cyc(int'($urandom_range(6, 0)));
        if ($urandom_range(40, 0) == 0) enable = ~enable;
        fault_clr = ($urandom_range(50, 0) == 0);
        send(int'($urandom_range(550, 250)));
        fault_clr = 1'b0;
      end
    end

    // Reset mid-PWM-high with a sample in flight
    enable = 1'b0; fault_clr = 1'b1; cyc(1); fault_clr = 1'b0;
    setpoint = 16'sd400; hysteresis = 16'd8; kp = 8'd16; enable = 1'b1;
    cyc(3);
    send(200); cyc(300);
    wait_pos(5);
    send(384);
    chk("heater_before_reset", int'(heater_pwm), 1);
    #2 ARESET = 1'b1;
    #1;
    chk("async_heater", int'(heater_pwm), 0);
    chk("async_duty", int'(duty), 0);
    chk("async_state", int'(state), 0);
    chk("async_fault", int'(fault), 0);
    chk("async_temp_last", int'(temp_last), 0);
    chk("async_s_ready", int'(sif.s_ready), 1);
    cyc(2);
    ARESET = 1'b0;
    cyc(10);
    chk("post_reset_temp_last", int'(temp_last), 0);
    chk("post_reset_duty", int'(duty), 0);

    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
